// File: rtl/hlsi_stream_arbiter.sv
// Round-robin arbiter sharing one kernel input stream among NUM_REQ producer streams.
// Grants one source at a time and passes its data/ready/enable handshake straight through.
module hlsi_stream_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8,
  localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_enable,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_ready,
  input  logic                          out_enable,
  output logic                          grant_valid,
  output logic [IdW-1:0]                grant_id
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic [DATA_WIDTH-1:0] req_words [NUM_REQ];
  logic                  sel_found;
  logic [IdW-1:0]        sel_idx;
  logic [IdW-1:0]        cand_idx;
  int unsigned           cand;
  logic [IdW-1:0]        next_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First ready requester at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IdW'(cand);
      if (!sel_found && req_ready[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign next_id = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          grant_id_d  = sel_idx;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        // A source running dry releases even if the kernel is accepting.
        if (!req_ready[grant_id_q]) begin
          state_d     = StIdle;
          rr_ptr_d    = next_id;
          burst_cnt_d = '0;
        end else if (out_enable) begin
          if (burst_cnt_q == CntW'(MAX_BURST - 1)) begin
            state_d     = StIdle;
            rr_ptr_d    = next_id;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    out_ready   = 1'b0;
    req_enable  = '0;
    out_data    = req_words[grant_id_q];
    grant_id    = grant_id_q;
    case (state_q)
      StGrant: begin
        grant_valid            = 1'b1;
        out_ready              = req_ready[grant_id_q];
        req_enable[grant_id_q] = out_enable;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/hlsi_stream_arbiter.md
# hlsi_stream_arbiter

Round-robin arbiter that shares one kernel input stream among NUM_REQ producer streams, all using the data/ready/enable handshake of the kernel chain. It sits between several upstream sources and the `dataL/readyL/enableL` port of a single kernel. It grants one requester at a time, passes its stream through, and re-arbitrates after a burst limit or when the granted source runs dry.

## Interface
Handshake convention: the producer drives `data` and `ready` (data valid). The consumer drives `enable` (accept). A beat transfers on a rising `sys_clk` edge where `ready && enable`.

Parameters:
- NUM_REQ, 4, number of requester streams (2..16)
- DATA_WIDTH, 32, stream data width
- MAX_BURST, 8, maximum beats per grant (1..256)

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  single clock; all state updates on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- req_data  in  NUM_REQ*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  in  NUM_REQ  per-requester data valid
- req_enable  out  NUM_REQ  per-requester accept
- out_data  out  DATA_WIDTH  data to the kernel (`dataL`)
- out_ready  out  1  valid to the kernel (`readyL`)
- out_enable  in  1  accept from the kernel (`enableL`)
- grant_valid  out  1  high while in GRANT
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester

## Operation
- State machine with two states.
- **IDLE**
  - out_ready=0 and req_enable=0.
  - If any req_ready bit is set, select the first set index at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - Register that index into grant_id, clear burst_cnt, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - Combinational passthrough: out_data=req_data[grant_id], out_ready=req_ready[grant_id], req_enable[grant_id]=out_enable.
  - All other req_enable bits are 0.
  - On each transfer, burst_cnt increments.
- **Release** (GRANT→IDLE at the same edge; only in GRANT):
  - (a) A transfer occurs with burst_cnt==MAX_BURST-1.
  - (b) req_ready[grant_id]==0 in the current cycle; no transfer occurs in that cycle.
  - On release, rr_ptr = (grant_id+1) mod NUM_REQ.
- out_data always equals req_data[grant_id], including in IDLE; it is don't-care while out_ready=0.
- burst_cnt is sized clog2(MAX_BURST+1) and never exceeds MAX_BURST-1.
- rr_ptr changes only on release.

## Timing
- **Reset values**: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, grant_valid=0, out_ready=0, req_enable=0.
- **Grant latency**: a req_ready rising in IDLE at cycle t gives grant_valid=1 and out_ready=1 in cycle t+1.
- **Re-arbitration bubble**: exactly one IDLE cycle between consecutive grants.
- **Peak throughput**: MAX_BURST beats per MAX_BURST+1 cycles.
- **Combinational paths**:
  - out_enable → req_enable.
  - req_ready[grant_id] → out_ready.
  - No registered stage on data.
- **Simultaneous requests**: after reset with all requesters asserting, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- **MAX_BURST=1**: every transfer releases.
- **Kernel back-pressure** (out_enable=0 while granted source is ready): hold GRANT with burst_cnt unchanged, no timeout.
- **Granted source drops ready mid-burst**: release immediately, even if out_enable=1 in that cycle.
- **sys_rst mid-burst**:
  - Outputs are still driven by current state in the reset cycle.
  - From the next cycle, all reset values apply and no partial-burst state survives.
  - A beat accepted in the reset cycle counts as transferred; the source must not resend it.

## Test plan
- **Reset then single source**: req_ready=4'b0100, data 0xA0..0xA9, out_enable=1.
  - Grant 2 from the cycle after request.
  - Beats 0xA0..0xA7 pass, then 1 bubble, then re-grant 2 with 0xA8, 0xA9.
  - rr_ptr=3 after the first release.
- **All four ready continuously**, MAX_BURST=8, out_enable=1:
  - grant_id sequence 0,1,2,3,0.
  - 8 beats each, 1 idle cycle between grants.
  - 32 beats in 36 cycles.
- **Back-pressure**: granted source 1 ready, out_enable toggles 1,0,0,1.
  - Only cycles with enable=1 transfer, and req_enable[1] mirrors out_enable.
  - burst_cnt goes 1,1,1,2.
- **Early release**: source 0 sends 3 beats, then drops ready while source 3 is ready.
  - Release after 3 beats, 1 idle cycle, then grant 3.
  - rr_ptr=1 after the release.
- **Mid-burst reset**: assert sys_rst for 1 cycle after 4 beats from source 2.
  - Next cycle: grant_valid=0, req_enable=0, rr_ptr=0.
  - With sources 0 and 2 ready, the next grant is 0.
- **MAX_BURST=1, NUM_REQ=2**, both ready:
  - Alternating grants 0,1,0,1.
  - 1 beat each, a beat every other cycle.
